tspi_rx_rxd_ctl: RTL and testbench

//   Receive-side data controller for the Tspi link; the counterpart of the transmit-side data controller.

---
 rtl/tspi_rx_rxd_ctl.sv | 133 +++++++++++++
 tb/tb_tspi_rx_rxd_ctl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tspi_rx_rxd_ctl.sv
// rtl/tspi_rx_rxd_ctl.sv - Tspi receive data controller: pin sync, MSB-first deserialiser, valid/ready word output
module tspi_rx_rxd_ctl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd_en,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_sdi,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_ovf,
    output logic [CNT_W-1:0]  rx_cnt,
    output logic              rxd_cmpt
);

    localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_CMPT} state_t;

    state_t            state_q;
    logic              sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic              cs_s1_q, cs_s2_q, cs_h_q;
    logic              sdi_s1_q, sdi_s2_q;
    logic [DATA_W-1:0] shift_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              rx_ovf_q;
    logic [CNT_W-1:0]  rx_cnt_q;
    logic              rxd_cmpt_q;

    logic              sclk_rise;
    logic              cs_rise;
    logic [DATA_W-1:0] shift_d;

    assign sclk_rise = sclk_s2_q & ~sclk_h_q;
    assign cs_rise   = cs_s2_q & ~cs_h_q;
    assign shift_d   = {shift_q[DATA_W-2:0], sdi_s2_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_h_q   <= 1'b0;
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            cs_h_q     <= 1'b1;
            sdi_s1_q   <= 1'b0;
            sdi_s2_q   <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
            rx_cnt_q   <= '0;
            rxd_cmpt_q <= 1'b0;
        end else begin
            sclk_s1_q <= spi_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            cs_s1_q   <= spi_cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            sdi_s1_q  <= spi_sdi;
            sdi_s2_q  <= sdi_s1_q;

            if (!rxd_en) begin
                // Teardown: rx_data deliberately keeps its last word
                state_q    <= S_IDLE;
                bit_cnt_q  <= '0;
                rx_valid_q <= 1'b0;
                rx_ovf_q   <= 1'b0;
                rx_cnt_q   <= '0;
                rxd_cmpt_q <= 1'b0;
            end else begin
                if (rx_valid_q && rx_ready) begin
                    rx_valid_q <= 1'b0;
                end
                case (state_q)
                    S_IDLE: begin
                        bit_cnt_q <= '0;
                        state_q   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (!cs_s2_q) begin
                            state_q <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (sclk_rise) begin
                            shift_q <= shift_d;
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q <= '0;
                                if (!rx_valid_q || rx_ready) begin
                                    rx_data_q  <= shift_d;
                                    rx_valid_q <= 1'b1;
                                    if (rx_cnt_q != {CNT_W{1'b1}}) begin
                                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                                    end
                                end else begin
                                    rx_ovf_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BW'(1);
                            end
                        end
                        // A word finishing on this same edge is handled above before leaving
                        if (cs_rise) begin
                            state_q <= S_CMPT;
                        end
                    end
                    S_CMPT: begin
                        rxd_cmpt_q <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_ovf   = rx_ovf_q;
    assign rx_cnt   = rx_cnt_q;
    assign rxd_cmpt = rxd_cmpt_q;

endmodule

// File: tb/tb_tspi_rx_rxd_ctl.sv
// tb/tb_tspi_rx_rxd_ctl.sv - self-checking bench for tspi_rx_rxd_ctl against a frame-level word model
module tb_tspi_rx_rxd_ctl;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rxd_en;
    logic          spi_sclk;
    logic          spi_cs_n;
    logic          spi_sdi;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rx_ovf;
    logic [CW-1:0] rx_cnt;
    logic          rxd_cmpt;

    tspi_rx_rxd_ctl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd_en   (rxd_en),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_sdi  (spi_sdi),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_ovf   (rx_ovf),
        .rx_cnt   (rx_cnt),
        .rxd_cmpt (rxd_cmpt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] got_q[$];
    int            vpulse;
    logic          vprev = 1'b0;

    // Handshakes and valid pulses observed mid-cycle, where inputs and outputs are settled
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_valid && !vprev) vpulse++;
        vprev = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input bit cs_too);
        spi_sdi = b;
        tick(4);
        spi_sclk = 1'b1;
        if (cs_too) spi_cs_n = 1'b1;
        tick(4);
        spi_sclk = 1'b0;
    endtask

    bit tx_bits[$];

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
    endtask

    task automatic drop_en(input string nm);
        rxd_en = 1'b0;
        tick(1);
        chk({nm, ".clr_cmpt"}, rxd_cmpt, 0);
        chk({nm, ".clr_cnt"}, rx_cnt, 0);
        chk({nm, ".clr_ovf"}, rx_ovf, 0);
        chk({nm, ".clr_valid"}, rx_valid, 0);
        rxd_en = 1'b1;
        tick(2);
    endtask

    // Expected words: complete groups of DW bits, first bit on the wire as MSB
    task automatic run_frame(input bit rdy, input bit cs_last, input string nm);
        int            nw;
        logic [DW-1:0] w;
        logic [DW-1:0] exp_w[$];
        nw = tx_bits.size() / DW;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int j = 0; j < DW; j++) w = {w[DW-2:0], 1'(tx_bits[i*DW+j])};
            exp_w.push_back(w);
        end
        got_q.delete();
        vpulse   = 0;
        rx_ready = rdy;
        spi_cs_n = 1'b0;
        tick(6);
        for (int i = 0; i < tx_bits.size(); i++)
            send_bit(tx_bits[i], cs_last && (i == tx_bits.size() - 1));
        tick(4);
        spi_cs_n = 1'b1;
        tick(10);
        chk({nm, ".cmpt"}, rxd_cmpt, 1);
        if (rdy) begin
            chk({nm, ".cnt"}, rx_cnt, nw);
            chk({nm, ".ovf"}, rx_ovf, 0);
            chk({nm, ".valid"}, rx_valid, 0);
            chk({nm, ".pulses"}, vpulse, nw);
            chk({nm, ".nwords"}, got_q.size(), nw);
            for (int i = 0; i < nw && i < got_q.size(); i++)
                chk({nm, ".word"}, got_q[i], exp_w[i]);
        end else begin
            chk({nm, ".cnt"}, rx_cnt, (nw > 0) ? 1 : 0);
            chk({nm, ".ovf"}, rx_ovf, (nw > 1) ? 1 : 0);
            chk({nm, ".valid"}, rx_valid, (nw > 0) ? 1 : 0);
            chk({nm, ".pulses"}, vpulse, (nw > 0) ? 1 : 0);
            if (nw > 0) begin
                chk({nm, ".held"}, rx_data, exp_w[0]);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                chk({nm, ".consumed"}, rx_valid, 0);
            end
        end
        tx_bits.delete();
        drop_en(nm);
    endtask

    initial begin
        rst      = 1'b1;
        rxd_en   = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_sdi  = 1'b0;
        rx_ready = 1'b0;
        tick(3);
        chk("rst.valid", rx_valid, 0);
        chk("rst.data", rx_data, 0);
        chk("rst.cnt", rx_cnt, 0);
        chk("rst.ovf", rx_ovf, 0);
        chk("rst.cmpt", rxd_cmpt, 0);
        rst = 1'b0;
        tick(2);
        rxd_en = 1'b1;
        tick(2);

        push_byte(8'hA5); push_byte(8'h3C);
        run_frame(1'b1, 1'b0, "t1");

        push_byte(8'h11); push_byte(8'h22);
        run_frame(1'b0, 1'b0, "t2");

        push_byte(8'hF0);
        for (int i = 0; i < 5; i++) tx_bits.push_back(i[0]);
        run_frame(1'b1, 1'b0, "t3");

        // Status set up (held word + overflow), then teardown mid-word and restart under CS
        rx_ready = 1'b0;
        spi_cs_n = 1'b0;
        tick(6);
        push_byte(8'h11); push_byte(8'h22);
        for (int i = 0; i < tx_bits.size(); i++) send_bit(tx_bits[i], 1'b0);
        tx_bits.delete();
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        chk("t4.pre_ovf", rx_ovf, 1);
        chk("t4.pre_data", rx_data, 8'h11);
        rxd_en = 1'b0;
        tick(1);
        chk("t4.drop_valid", rx_valid, 0);
        chk("t4.drop_ovf", rx_ovf, 0);
        chk("t4.drop_cnt", rx_cnt, 0);
        chk("t4.drop_data", rx_data, 8'h11);
        rxd_en = 1'b1;
        rx_ready = 1'b1;
        got_q.delete();
        tick(6);
        push_byte(8'h81);
        for (int i = 0; i < tx_bits.size(); i++) send_bit(tx_bits[i], 1'b0);
        tx_bits.delete();
        tick(8);
        chk("t4.cnt", rx_cnt, 1);
        chk("t4.nwords", got_q.size(), 1);
        if (got_q.size() > 0) chk("t4.word", got_q[0], 8'h81);
        spi_cs_n = 1'b1;
        tick(10);
        chk("t4.cmpt", rxd_cmpt, 1);
        drop_en("t4");

        rx_ready = 1'b0;
        spi_cs_n = 1'b0;
        tick(6);
        push_byte(8'hC3);
        for (int i = 0; i < tx_bits.size(); i++) send_bit(tx_bits[i], 1'b0);
        tx_bits.delete();
        tick(6);
        chk("t5.pre_valid", rx_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5.async_valid", rx_valid, 0);
        chk("t5.async_data", rx_data, 0);
        chk("t5.async_cnt", rx_cnt, 0);
        tick(2);
        rst = 1'b0;
        spi_cs_n = 1'b1;
        tick(3);
        push_byte(8'h5A);
        run_frame(1'b1, 1'b0, "t5");

        push_byte(8'h7E);
        run_frame(1'b1, 1'b1, "t6");

        for (int f = 0; f < 6; f++) begin
            int nb;
            nb = $urandom_range(0, 36);
            for (int i = 0; i < nb; i++) tx_bits.push_back(1'($urandom));
            run_frame(1'($urandom), 1'($urandom), $sformatf("rnd%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
